// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizes for the four-channel mux scan controller.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle down-counter: load a value, count down while enabled, flag zero.
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Parks at zero; it only leaves zero through a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps an external 4:1 mux through all channels, lets each settle, samples
// it, and presents the complete scan as a frame with a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start, selects parked at 00
// SETTLE | select lines driving ch, waiting SETTLE_CYCLES clocks
// SAMPLE | one clock, mux_out captured into shadow bit ch
// HOLD   | complete frame presented, waiting for frame_ready
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              mux_out,
  output logic              sel1,
  output logic              sel0,
  output logic              busy,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
  input  logic              frame_ready
);

  // The timer hits zero on its last SETTLE clock, so it is loaded one short.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  state_t            state;
  logic [SEL_W-1:0]  ch;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_next;
  logic              timer_load;
  logic              timer_done;
  logic              handshake;

  assign handshake = (state == HOLD) && frame_ready;

  always_comb begin
    timer_load = 1'b0;
    case (state)
      IDLE:    timer_load = start;
      SAMPLE:  timer_load = (ch != LAST_CH);
      HOLD:    timer_load = frame_ready && cont;
      default: timer_load = 1'b0;
    endcase
  end

  always_comb begin
    shadow_next     = shadow;
    shadow_next[ch] = mux_out;
  end

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (state == SETTLE),
    .load_val (RELOAD),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= '0;
      shadow <= '0;
      frame  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch    <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_done) state <= SAMPLE;
        end
        SAMPLE: begin
          shadow <= shadow_next;
          if (ch == LAST_CH) begin
            frame <= shadow_next;
            state <= HOLD;
          end else begin
            ch    <= ch + 1'b1;
            state <= SETTLE;
          end
        end
        HOLD: begin
          if (handshake) begin
            ch    <= '0;
            state <= cont ? SETTLE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {sel1, sel0}  = ((state == SETTLE) || (state == SAMPLE)) ? ch : '0;
  assign busy          = (state != IDLE);
  assign frame_valid   = (state == HOLD);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: default build plus a SETTLE_CYCLES=1
// build behind a slow (30-unit) mux on a 40-unit clock.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst, start, cont, frame_ready, mux_out;
  logic       sel1, sel0, busy, frame_valid;
  logic [3:0] frame, in_vec;

  logic       start_f, frame_ready_f, mux_out_f;
  logic       sel1_f, sel0_f, busy_f, frame_valid_f;
  logic [3:0] frame_f, in_f;

  assign #1  mux_out   = in_vec[{sel1, sel0}];
  assign #30 mux_out_f = in_f[{sel1_f, sel0_f}];

  mux_scan_ctrl #(.SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_out(mux_out),
    .sel1(sel1), .sel0(sel0), .busy(busy), .frame(frame),
    .frame_valid(frame_valid), .frame_ready(frame_ready)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst), .start(start_f), .cont(1'b0), .mux_out(mux_out_f),
    .sel1(sel1_f), .sel0(sel0_f), .busy(busy_f), .frame(frame_f),
    .frame_valid(frame_valid_f), .frame_ready(frame_ready_f)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Call right after the edge that accepted start (or the cont handshake).
  task automatic watch_scan(input logic [3:0] old_frame, input bit disturb);
    logic [3:0] exp;
    for (int k = 1; k <= 16; k++) begin
      if (disturb) begin
        start       = k[0];
        frame_ready = 1'b1;
      end
      tick();
      total++;
      if (frame_valid !== (k == 16)) begin
        bad++;
        $display("FAIL valid_edge k=%0d got=%b want=%b", k, frame_valid, (k == 16));
      end
      if (k < 16) begin
        total++;
        if ({sel1, sel0} !== 2'(k / 4)) begin
          bad++;
          $display("FAIL sel_seq k=%0d got=%b want=%b", k, {sel1, sel0}, 2'(k / 4));
        end
        total++;
        if (frame !== old_frame) begin
          bad++;
          $display("FAIL frame_stable k=%0d got=%b want=%b", k, frame, old_frame);
        end
      end
    end
    start       = 1'b0;
    frame_ready = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%0d want=1", exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (frame !== exp) begin
        bad++;
        $display("FAIL frame_value got=%b want=%b", frame, exp);
      end
    end
  endtask

  task automatic release_idle;
    cont        = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_idle busy=%b valid=%b want=0,0", busy, frame_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({busy, frame_valid, sel1, sel0, frame} !== 8'h00) begin
      bad++;
      $display("FAIL %s busy=%b valid=%b sel=%b frame=%b want all 0",
               tag, busy, frame_valid, {sel1, sel0}, frame);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cont = 1'b0; frame_ready = 1'b0; in_vec = 4'b0;
    start_f = 1'b0; frame_ready_f = 1'b0; in_f = 4'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");
    total++;
    if ({busy_f, frame_valid_f, frame_f} !== 6'b0) begin
      bad++;
      $display("FAIL reset_fast busy=%b valid=%b frame=%b want 0", busy_f, frame_valid_f, frame_f);
    end
  endtask

  task automatic test_single_scan;
    in_vec = 4'b1101;
    exp_q.push_back(4'b1101);
    start = 1'b1;
    tick();
    start = 1'b0;
    watch_scan(4'b0000, 1'b0);
  endtask

  task automatic test_hold_stall;
    for (int k = 0; k < 10; k++) begin
      in_vec = 4'(k);
      tick();
      total++;
      if (frame_valid !== 1'b1 || frame !== 4'b1101) begin
        bad++;
        $display("FAIL hold_stall k=%0d valid=%b frame=%b want 1,1101", k, frame_valid, frame);
      end
    end
    release_idle();
    total++;
    if (frame !== 4'b1101) begin
      bad++;
      $display("FAIL frame_after_idle got=%b want=1101", frame);
    end
  endtask

  task automatic test_back_to_back;
    in_vec = 4'b1101;
    exp_q.push_back(4'b1101);
    start = 1'b1;
    tick();
    start = 1'b0;
    watch_scan(4'b1101, 1'b0);
    in_vec = 4'b0110;
    exp_q.push_back(4'b0110);
    cont = 1'b1;
    frame_ready = 1'b1;
    tick();
    cont = 1'b0;
    frame_ready = 1'b0;
    total++;
    if (frame_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL cont_restart valid=%b busy=%b want 0,1", frame_valid, busy);
    end
    watch_scan(4'b1101, 1'b0);
    release_idle();
  endtask

  task automatic test_reset_mid_scan;
    in_vec = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    total++;
    if ({sel1, sel0} !== 2'b10 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_sel got=%b busy=%b want 10,1", {sel1, sel0}, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("reset_mid");
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_all_zero("reset_over_start");
    in_vec = 4'b1011;
    exp_q.push_back(4'b1011);
    start = 1'b1;
    tick();
    start = 1'b0;
    watch_scan(4'b0000, 1'b0);
    release_idle();
  endtask

  task automatic test_start_ignored;
    in_vec = 4'b0101;
    exp_q.push_back(4'b0101);
    start = 1'b1;
    tick();
    watch_scan(4'b1011, 1'b1);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (frame_valid !== 1'b1 || frame !== 4'b0101) begin
        bad++;
        $display("FAIL start_in_hold k=%0d valid=%b frame=%b want 1,0101", k, frame_valid, frame);
      end
    end
    start = 1'b0;
    release_idle();
    tick(); tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_queued busy=%b want 0", busy);
    end
  endtask

  task automatic test_fast_build;
    logic [3:0] exp;
    in_f = 4'b1010;
    exp_q.push_back(4'b1010);
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (frame_valid_f !== (k == 8)) begin
        bad++;
        $display("FAIL fast_valid k=%0d got=%b want=%b", k, frame_valid_f, (k == 8));
      end
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL fast_scoreboard_empty got=0 want=1");
    end else begin
      exp = exp_q.pop_front();
      if (frame_f !== exp) begin
        bad++;
        $display("FAIL fast_frame got=%b want=%b", frame_f, exp);
      end
    end
    frame_ready_f = 1'b1;
    tick();
    frame_ready_f = 1'b0;
    total++;
    if (busy_f !== 1'b0 || frame_valid_f !== 1'b0) begin
      bad++;
      $display("FAIL fast_idle busy=%b valid=%b want 0,0", busy_f, frame_valid_f);
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid_scan();
    test_start_ignored();
    test_fast_build();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
